// File: rtl/softmax_job_sched_pkg.sv
// Shared definitions for the softmax job scheduler: FSM state encoding and
// the field layout of a job record as stored in the job FIFO.
package softmax_job_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_INIT  = 3'd2,
        ST_START = 3'd3,
        ST_WAIT  = 3'd4,
        ST_FLUSH = 3'd5
    } sched_state_e;

    // Job record = {dst_base, src_end, src_start}, each field ADDRSIZE wide.
    localparam int JOB_FIELDS      = 3;
    localparam int JOB_SRC_START_F = 0;
    localparam int JOB_SRC_END_F   = 1;
    localparam int JOB_DST_BASE_F  = 2;

endpackage

// File: rtl/softmax_job_sched_if.sv
// Host/DMA job command port: valid/ready handshake carrying one job record.
interface softmax_job_sched_if #(
    parameter int ADDRSIZE = 8
) ();
    logic                job_valid;
    logic                job_ready;
    logic [ADDRSIZE-1:0] job_src_start;
    logic [ADDRSIZE-1:0] job_src_end;
    logic [ADDRSIZE-1:0] job_dst_base;

    modport master (output job_valid, job_src_start, job_src_end, job_dst_base,
                    input  job_ready);
    modport slave  (input  job_valid, job_src_start, job_src_end, job_dst_base,
                    output job_ready);
endinterface

// File: rtl/softmax_job_sched_fifo.sv
// Synchronous job FIFO with registered count; head entry is visible on rdata
// whenever the FIFO is non-empty. Push and pop may coincide, even when full.
module softmax_job_fifo
    import softmax_job_sched_pkg::*;
#(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = (count_q == (PW+1)'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/softmax_job_sched.sv
// Sequences one softmax datapath over queued vector jobs: clear, init, start,
// wait for done, generate write-back addresses, with a watchdog abort path.
module softmax_job_sched
    import softmax_job_sched_pkg::*;
#(
    parameter int ADDRSIZE = 8,
    parameter int QDEPTH   = 4,
    parameter int TMO_CYC  = 4096,
    parameter int TMO_W    = 13
) (
    input  logic                clk,
    input  logic                reset,
    softmax_job_sched_if.slave  job,
    output logic                sm_reset,
    output logic                sm_init,
    output logic                sm_start,
    output logic [ADDRSIZE-1:0] sm_start_addr,
    output logic [ADDRSIZE-1:0] sm_end_addr,
    input  logic                sm_done,
    output logic                wr_en,
    output logic [ADDRSIZE-1:0] wr_addr,
    output logic                busy,
    output logic                job_done,
    output logic                err_timeout
);
    localparam int JW        = JOB_FIELDS * ADDRSIZE;
    localparam int SRC_S_LSB = JOB_SRC_START_F * ADDRSIZE;
    localparam int SRC_E_LSB = JOB_SRC_END_F * ADDRSIZE;
    localparam int DST_LSB   = JOB_DST_BASE_F * ADDRSIZE;

    sched_state_e        state_q, state_d;
    logic [ADDRSIZE-1:0] src_start_q, src_start_d;
    logic [ADDRSIZE-1:0] src_end_q, src_end_d;
    logic [ADDRSIZE-1:0] wr_addr_q, wr_addr_d;
    logic [TMO_W-1:0]    wd_q, wd_d;
    logic                done_seen_q, done_seen_d;
    logic                done_prev_q, done_prev_d;
    logic                flush_q, flush_d;
    logic                err_q, err_d;

    logic          fifo_push, fifo_pop, fifo_full, fifo_empty, ready;
    logic [JW-1:0] fifo_head, fifo_wdata;
    logic          in_wait, done_fall, timeout;

    // A pop frees a slot in the same cycle, so a full FIFO may still accept.
    assign fifo_pop      = (state_q == ST_IDLE) && !fifo_empty;
    assign ready         = !fifo_full || fifo_pop;
    assign fifo_push     = job.job_valid && ready;
    assign fifo_wdata    = {job.job_dst_base, job.job_src_end, job.job_src_start};
    assign job.job_ready = ready;

    softmax_job_fifo #(
        .WIDTH (JW),
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (fifo_wdata),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign in_wait   = (state_q == ST_WAIT);
    assign done_fall = in_wait && done_prev_q && !sm_done;
    assign timeout   = in_wait && !done_seen_q && !sm_done
                       && (wd_q == TMO_W'(TMO_CYC - 1));

    always_comb begin
        state_d     = state_q;
        src_start_d = src_start_q;
        src_end_d   = src_end_q;
        wr_addr_d   = wr_addr_q;
        wd_d        = wd_q;
        done_seen_d = done_seen_q;
        flush_d     = flush_q;
        err_d       = err_q;
        // Edge detector only tracks done inside WAIT so stray pulses are ignored.
        done_prev_d = in_wait && sm_done;
        case (state_q)
            ST_IDLE: begin
                if (fifo_pop) begin
                    src_start_d = fifo_head[SRC_S_LSB +: ADDRSIZE];
                    src_end_d   = fifo_head[SRC_E_LSB +: ADDRSIZE];
                    wr_addr_d   = fifo_head[DST_LSB +: ADDRSIZE];
                    state_d     = ST_CLEAR;
                end
            end
            ST_CLEAR: state_d = ST_INIT;
            ST_INIT:  state_d = ST_START;
            ST_START: begin
                wd_d        = '0;
                done_seen_d = 1'b0;
                state_d     = ST_WAIT;
            end
            ST_WAIT: begin
                if (sm_done) begin
                    wr_addr_d   = wr_addr_q + ADDRSIZE'(1);
                    done_seen_d = 1'b1;
                end
                if (done_fall) begin
                    state_d = ST_IDLE;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    flush_d = 1'b0;
                    state_d = ST_FLUSH;
                end else if (!done_seen_q && !sm_done) begin
                    wd_d = wd_q + TMO_W'(1);
                end
            end
            ST_FLUSH: begin
                flush_d = 1'b1;
                if (flush_q) begin
                    flush_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            src_start_q <= '0;
            src_end_q   <= '0;
            wr_addr_q   <= '0;
            wd_q        <= '0;
            done_seen_q <= 1'b0;
            done_prev_q <= 1'b0;
            flush_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            src_start_q <= src_start_d;
            src_end_q   <= src_end_d;
            wr_addr_q   <= wr_addr_d;
            wd_q        <= wd_d;
            done_seen_q <= done_seen_d;
            done_prev_q <= done_prev_d;
            flush_q     <= flush_d;
            err_q       <= err_d;
        end
    end

    assign sm_reset      = (state_q == ST_IDLE) || (state_q == ST_CLEAR) || (state_q == ST_FLUSH);
    assign sm_init       = (state_q == ST_INIT);
    assign sm_start      = (state_q == ST_START);
    assign sm_start_addr = src_start_q;
    assign sm_end_addr   = src_end_q;
    assign wr_en         = in_wait && sm_done;
    assign wr_addr       = wr_addr_q;
    assign busy          = (state_q != ST_IDLE);
    assign job_done      = done_fall;
    assign err_timeout   = err_q;

endmodule

// File: tb/tb_softmax_job_sched.sv
// Directed bench for softmax_job_sched: single job, queue fill/order, address
// wrap, watchdog abort, mid-job reset and stray done pulses.
module tb_softmax_job_sched;
    localparam int AW  = 8;
    localparam int TMO = 4096;

    logic          clk = 1'b0;
    logic          reset;
    logic          sm_done;
    logic          sm_reset, sm_init, sm_start, wr_en, busy, job_done, err_timeout;
    logic [AW-1:0] sm_start_addr, sm_end_addr, wr_addr;
    int            n_cmp, n_err;

    softmax_job_sched_if #(.ADDRSIZE(AW)) jif ();

    softmax_job_sched #(
        .ADDRSIZE (AW),
        .QDEPTH   (4),
        .TMO_CYC  (TMO),
        .TMO_W    (13)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .job           (jif),
        .sm_reset      (sm_reset),
        .sm_init       (sm_init),
        .sm_start      (sm_start),
        .sm_start_addr (sm_start_addr),
        .sm_end_addr   (sm_end_addr),
        .sm_done       (sm_done),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .busy          (busy),
        .job_done      (job_done),
        .err_timeout   (err_timeout)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_job(input logic [AW-1:0] s, input logic [AW-1:0] e, input logic [AW-1:0] d);
        jif.job_src_start = s;
        jif.job_src_end   = e;
        jif.job_dst_base  = d;
    endtask

    task automatic wait_start(output bit found);
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (sm_start === 1'b1) begin
                found = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        repeat (2) step();
        #1;
        n_cmp++; if (sm_reset !== 1'b1) begin n_err++; $display("FAIL rst_sm_reset got %b want 1", sm_reset); end
        n_cmp++; if (jif.job_ready !== 1'b1) begin n_err++; $display("FAIL rst_job_ready got %b want 1", jif.job_ready); end
        n_cmp++; if ({busy, sm_init, sm_start, wr_en, job_done, err_timeout} !== 6'b0) begin
            n_err++; $display("FAIL rst_ctrl got %b want 000000", {busy, sm_init, sm_start, wr_en, job_done, err_timeout}); end
        n_cmp++; if ({sm_start_addr, sm_end_addr, wr_addr} !== 24'h0) begin
            n_err++; $display("FAIL rst_addr got %h want 000000", {sm_start_addr, sm_end_addr, wr_addr}); end
        reset = 1'b1;
        step();
    endtask

    task automatic test_single();
        logic [AW-1:0] e;
        jif.job_valid = 1'b1;
        set_job(8'h00, 8'h07, 8'h40);
        #1;
        n_cmp++; if (jif.job_ready !== 1'b1) begin n_err++; $display("FAIL single_ready got %b want 1", jif.job_ready); end
        step();
        jif.job_valid = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_idle_busy got %b want 0", busy); end
        step(); #1;
        n_cmp++; if ({sm_reset, busy, sm_init} !== 3'b110) begin n_err++; $display("FAIL single_clear got %b want 110", {sm_reset, busy, sm_init}); end
        n_cmp++; if ({sm_start_addr, sm_end_addr} !== 16'h0007) begin n_err++; $display("FAIL single_addrs got %h want 0007", {sm_start_addr, sm_end_addr}); end
        step(); #1;
        n_cmp++; if ({sm_init, sm_reset, sm_start} !== 3'b100) begin n_err++; $display("FAIL single_init got %b want 100", {sm_init, sm_reset, sm_start}); end
        step(); #1;
        n_cmp++; if ({sm_start, sm_init} !== 2'b10) begin n_err++; $display("FAIL single_start got %b want 10", {sm_start, sm_init}); end
        step();
        for (int i = 0; i < 8; i++) begin
            sm_done = 1'b1;
            e = 8'(8'h40 + i);
            #1;
            n_cmp++; if ({wr_en, job_done, wr_addr} !== {2'b10, e}) begin
                n_err++; $display("FAIL single_beat%0d got en=%b jd=%b addr=%h want en=1 jd=0 addr=%h", i, wr_en, job_done, wr_addr, e); end
            step();
        end
        sm_done = 1'b0;
        #1;
        n_cmp++; if ({job_done, wr_en} !== 2'b10) begin n_err++; $display("FAIL single_job_done got %b want 10", {job_done, wr_en}); end
        step(); #1;
        n_cmp++; if ({busy, job_done} !== 2'b00) begin n_err++; $display("FAIL single_end got %b want 00", {busy, job_done}); end
    endtask

    // Job k: src k*16 .. k*16+3, dst 0x80 + k*8. Job 0 is popped at once,
    // jobs 1..4 fill the FIFO, job 5 must wait for the next pop.
    task automatic test_back_to_back();
        int stall_bad;
        logic [AW-1:0] s;
        for (int k = 0; k < 5; k++) begin
            jif.job_valid = 1'b1;
            set_job(8'(k * 16), 8'(k * 16 + 3), 8'(128 + k * 8));
            #1;
            n_cmp++; if (jif.job_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready_push%0d got %b want 1", k, jif.job_ready); end
            step();
        end
        set_job(8'd80, 8'd83, 8'(128 + 40));
        #1;
        n_cmp++; if (jif.job_ready !== 1'b0) begin n_err++; $display("FAIL b2b_full_ready got %b want 0", jif.job_ready); end
        stall_bad = 0;
        repeat (5) begin
            step(); #1;
            if (jif.job_ready !== 1'b0) stall_bad++;
        end
        n_cmp++; if (stall_bad != 0) begin n_err++; $display("FAIL b2b_stall got %0d ready cycles want 0", stall_bad); end
        sm_done = 1'b1; #1;
        n_cmp++; if (wr_addr !== 8'h80) begin n_err++; $display("FAIL b2b_job0_addr got %h want 80", wr_addr); end
        step(); #1;
        n_cmp++; if (wr_addr !== 8'h81) begin n_err++; $display("FAIL b2b_job0_addr2 got %h want 81", wr_addr); end
        step();
        sm_done = 1'b0; #1;
        n_cmp++; if ({job_done, jif.job_ready} !== 2'b10) begin n_err++; $display("FAIL b2b_job0_done got %b want 10", {job_done, jif.job_ready}); end
        step(); #1;
        n_cmp++; if ({jif.job_ready, busy} !== 2'b10) begin n_err++; $display("FAIL b2b_pop_ready got %b want 10", {jif.job_ready, busy}); end
        step();
        jif.job_valid = 1'b0;
        #1;
        n_cmp++; if (jif.job_ready !== 1'b0) begin n_err++; $display("FAIL b2b_count_kept got ready=%b want 0", jif.job_ready); end
        for (int j = 1; j <= 5; j++) begin
            s = 8'(j * 16);
            n_cmp++; if ({sm_reset, busy, sm_start_addr, sm_end_addr} !== {2'b11, s, 8'(s + 3)}) begin
                n_err++; $display("FAIL b2b_order%0d got rst=%b busy=%b src=%h end=%h want 1 1 %h %h", j, sm_reset, busy, sm_start_addr, sm_end_addr, s, 8'(s + 3)); end
            step(); step(); #1;
            n_cmp++; if (sm_start !== 1'b1) begin n_err++; $display("FAIL b2b_start%0d got %b want 1", j, sm_start); end
            step();
            sm_done = 1'b1; #1;
            n_cmp++; if ({wr_en, wr_addr} !== {1'b1, 8'(128 + j * 8)}) begin
                n_err++; $display("FAIL b2b_wr%0d got en=%b addr=%h want 1 %h", j, wr_en, wr_addr, 8'(128 + j * 8)); end
            step();
            sm_done = 1'b0; #1;
            n_cmp++; if (job_done !== 1'b1) begin n_err++; $display("FAIL b2b_done%0d got %b want 1", j, job_done); end
            step(); #1;
            n_cmp++; if ({busy, sm_reset} !== 2'b01) begin n_err++; $display("FAIL b2b_idle%0d got %b want 01", j, {busy, sm_reset}); end
            step(); #1;
        end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_drained got busy=%b want 0", busy); end
    endtask

    task automatic test_wrap();
        bit found;
        logic [AW-1:0] exp_a [4];
        exp_a = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        jif.job_valid = 1'b1;
        set_job(8'h01, 8'h02, 8'hFE);
        step();
        jif.job_valid = 1'b0;
        wait_start(found);
        n_cmp++; if (found !== 1'b1) begin n_err++; $display("FAIL wrap_start got %b want 1", found); end
        step();
        for (int i = 0; i < 4; i++) begin
            sm_done = 1'b1; #1;
            n_cmp++; if ({wr_en, wr_addr} !== {1'b1, exp_a[i]}) begin
                n_err++; $display("FAIL wrap_beat%0d got en=%b addr=%h want 1 %h", i, wr_en, wr_addr, exp_a[i]); end
            step();
        end
        sm_done = 1'b0; #1;
        n_cmp++; if (job_done !== 1'b1) begin n_err++; $display("FAIL wrap_done got %b want 1", job_done); end
        step();
    endtask

    task automatic test_timeout();
        bit found;
        int seen;
        jif.job_valid = 1'b1;
        set_job(8'h10, 8'h05, 8'h20);
        step();
        set_job(8'h30, 8'h33, 8'h50);
        step();
        jif.job_valid = 1'b0;
        wait_start(found);
        n_cmp++; if ({found, sm_start_addr, sm_end_addr} !== {1'b1, 8'h10, 8'h05}) begin
            n_err++; $display("FAIL tmo_start got found=%b src=%h end=%h want 1 10 05", found, sm_start_addr, sm_end_addr); end
        step();
        seen = 0;
        for (int i = 1; i < TMO; i++) begin
            step(); #1;
            if (job_done !== 1'b0 || wr_en !== 1'b0) seen++;
        end
        n_cmp++; if ({err_timeout, sm_reset, busy} !== 3'b001) begin
            n_err++; $display("FAIL tmo_last_wait got %b want 001", {err_timeout, sm_reset, busy}); end
        step(); #1;
        n_cmp++; if ({err_timeout, sm_reset, busy, job_done} !== 4'b1110) begin
            n_err++; $display("FAIL tmo_flush1 got %b want 1110", {err_timeout, sm_reset, busy, job_done}); end
        step(); #1;
        n_cmp++; if ({sm_reset, busy, job_done} !== 3'b110) begin n_err++; $display("FAIL tmo_flush2 got %b want 110", {sm_reset, busy, job_done}); end
        step(); #1;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL tmo_idle got busy=%b want 0", busy); end
        n_cmp++; if (seen != 0) begin n_err++; $display("FAIL tmo_no_done got %0d events want 0", seen); end
        step(); #1;
        n_cmp++; if ({busy, sm_start_addr} !== {1'b1, 8'h30}) begin n_err++; $display("FAIL tmo_next_job got busy=%b src=%h want 1 30", busy, sm_start_addr); end
        step(); step(); step();
        sm_done = 1'b1; #1;
        n_cmp++; if ({wr_en, wr_addr} !== {1'b1, 8'h50}) begin n_err++; $display("FAIL tmo_next_wr got en=%b addr=%h want 1 50", wr_en, wr_addr); end
        step();
        sm_done = 1'b0; #1;
        n_cmp++; if ({job_done, err_timeout} !== 2'b11) begin n_err++; $display("FAIL tmo_next_done got %b want 11", {job_done, err_timeout}); end
        step();
    endtask

    task automatic test_reset_mid();
        bit found;
        int bad;
        jif.job_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            set_job(8'(8'h60 + k), 8'h68, 8'hA0);
            step();
        end
        jif.job_valid = 1'b0;
        wait_start(found);
        n_cmp++; if (found !== 1'b1) begin n_err++; $display("FAIL rmid_start got %b want 1", found); end
        step();
        sm_done = 1'b1; #1;
        n_cmp++; if (wr_en !== 1'b1) begin n_err++; $display("FAIL rmid_wr_before got %b want 1", wr_en); end
        reset = 1'b0; #1;
        n_cmp++; if ({busy, sm_reset, wr_en, jif.job_ready, err_timeout, sm_init, sm_start} !== 7'b0101000) begin
            n_err++; $display("FAIL rmid_ctrl got %b want 0101000", {busy, sm_reset, wr_en, jif.job_ready, err_timeout, sm_init, sm_start}); end
        n_cmp++; if ({sm_start_addr, sm_end_addr, wr_addr} !== 24'h0) begin
            n_err++; $display("FAIL rmid_addr got %h want 000000", {sm_start_addr, sm_end_addr, wr_addr}); end
        step();
        reset = 1'b1;
        bad = 0;
        repeat (6) begin
            step(); #1;
            if (busy !== 1'b0 || wr_en !== 1'b0) bad++;
        end
        n_cmp++; if (bad != 0) begin n_err++; $display("FAIL rmid_after got %0d active cycles want 0", bad); end
        sm_done = 1'b0;
    endtask

    task automatic test_idle_done();
        int bad;
        sm_done = 1'b1;
        bad = 0;
        repeat (3) begin
            step(); #1;
            if (wr_en !== 1'b0 || busy !== 1'b0) bad++;
        end
        n_cmp++; if (bad != 0) begin n_err++; $display("FAIL idle_done_wr got %0d bad cycles want 0", bad); end
        jif.job_valid = 1'b1;
        set_job(8'h70, 8'h71, 8'h33);
        step();
        jif.job_valid = 1'b0;
        bad = 0;
        repeat (4) begin
            #1;
            if (wr_en !== 1'b0 || job_done !== 1'b0) bad++;
            step();
        end
        n_cmp++; if (bad != 0) begin n_err++; $display("FAIL pre_wait_done got %0d bad cycles want 0", bad); end
        #1;
        n_cmp++; if ({wr_en, wr_addr, job_done} !== {1'b1, 8'h33, 1'b0}) begin
            n_err++; $display("FAIL held_done_wait got en=%b addr=%h jd=%b want 1 33 0", wr_en, wr_addr, job_done); end
        step();
        sm_done = 1'b0; #1;
        n_cmp++; if (job_done !== 1'b1) begin n_err++; $display("FAIL held_done_end got %b want 1", job_done); end
        step();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b0;
        sm_done = 1'b0;
        jif.job_valid = 1'b0;
        set_job(8'h00, 8'h00, 8'h00);
        test_reset();
        test_single();
        test_back_to_back();
        test_wrap();
        test_timeout();
        test_reset_mid();
        test_idle_done();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation still running at %0t, limit 1000000", $time);
        $fatal(1);
    end

endmodule
